// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder with a one-word holding register for gap-free streaming.
// Optional macro SER_PARITY_EN appends an even-parity bit to every frame.
module bit_serializer #(
  parameter int   DATA_W     = 8,
  parameter int   MSB_FIRST  = 1,
  parameter logic IDLE_LEVEL = 1'b0,
  parameter int   CNT_W      = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] DIN,
  input  logic              DIN_VALID,
  output logic              DIN_READY,
  output logic              SOUT,
  output logic              SOUT_VALID,
  output logic              WORD_DONE,
  output logic              BUSY,
  output logic [CNT_W-1:0]  WORD_CNT
);

  localparam int BC_W = $clog2(DATA_W + 1);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_W);
`ifndef SER_PARITY_EN
  localparam logic [BC_W-1:0] PENULT_BIT = BC_W'(DATA_W - 1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1
`ifdef SER_PARITY_EN
    , ST_PAR = 2'd2
`endif
  } state_t;

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] sr_reg, sr_next;
  logic [DATA_W-1:0] hold_reg, hold_next;
  logic              hold_full_reg, hold_full_next;
  logic [BC_W-1:0]   bit_cnt_reg, bit_cnt_next;
  logic              sout_reg, sout_next;
  logic              sout_valid_reg, sout_valid_next;
  logic              word_done_reg, word_done_next;
  logic [CNT_W-1:0]  word_cnt_reg;
`ifdef SER_PARITY_EN
  logic              parity_reg, parity_next;
`endif

  logic              xfer;
  logic              load_slot;
  logic              do_load;
  logic [DATA_W-1:0] load_word;

  // Bit that leaves first, and the word left after removing it.
  function automatic logic head_bit(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
  endfunction

  assign DIN_READY  = !hold_full_reg && !RST;
  assign xfer       = DIN_VALID && DIN_READY;
  assign SOUT       = sout_reg;
  assign SOUT_VALID = sout_valid_reg;
  assign WORD_DONE  = word_done_reg;
  assign BUSY       = sout_valid_reg || hold_full_reg;
  assign WORD_CNT   = word_cnt_reg;

`ifdef SER_PARITY_EN
  assign load_slot = (state_reg == ST_IDLE) || (state_reg == ST_PAR);
`else
  assign load_slot = (state_reg == ST_IDLE) ||
                     ((state_reg == ST_SHIFT) && (bit_cnt_reg == LAST_BIT));
`endif

  always_comb begin
    state_next      = state_reg;
    sr_next         = sr_reg;
    hold_next       = hold_reg;
    hold_full_next  = hold_full_reg;
    bit_cnt_next    = bit_cnt_reg;
    sout_next       = sout_reg;
    sout_valid_next = sout_valid_reg;
    word_done_next  = 1'b0;
    do_load         = 1'b0;
    load_word       = hold_reg;
`ifdef SER_PARITY_EN
    parity_next     = parity_reg;
`endif

    if (load_slot) begin
      // Held word has priority; DIN_READY is low then, so no accept can collide.
      if (hold_full_reg) begin
        do_load        = 1'b1;
        hold_full_next = 1'b0;
      end else if (xfer) begin
        do_load   = 1'b1;
        load_word = DIN;
      end else begin
        state_next      = ST_IDLE;
        sout_next       = IDLE_LEVEL;
        sout_valid_next = 1'b0;
        bit_cnt_next    = '0;
      end
    end else begin
      if (xfer) begin
        hold_next      = DIN;
        hold_full_next = 1'b1;
      end
      if (state_reg == ST_SHIFT) begin
`ifdef SER_PARITY_EN
        if (bit_cnt_reg == LAST_BIT) begin
          state_next     = ST_PAR;
          sout_next      = parity_reg;
          word_done_next = 1'b1;
        end else begin
          sout_next    = head_bit(sr_reg);
          sr_next      = advance(sr_reg);
          bit_cnt_next = bit_cnt_reg + 1'b1;
        end
`else
        sout_next      = head_bit(sr_reg);
        sr_next        = advance(sr_reg);
        bit_cnt_next   = bit_cnt_reg + 1'b1;
        word_done_next = (bit_cnt_reg == PENULT_BIT);
`endif
      end
    end

    if (do_load) begin
      state_next      = ST_SHIFT;
      sout_next       = head_bit(load_word);
      sr_next         = advance(load_word);
      sout_valid_next = 1'b1;
      bit_cnt_next    = BC_W'(1);
`ifdef SER_PARITY_EN
      parity_next     = ^load_word;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg      <= ST_IDLE;
      sr_reg         <= '0;
      hold_reg       <= '0;
      hold_full_reg  <= 1'b0;
      bit_cnt_reg    <= '0;
      sout_reg       <= IDLE_LEVEL;
      sout_valid_reg <= 1'b0;
      word_done_reg  <= 1'b0;
      word_cnt_reg   <= '0;
`ifdef SER_PARITY_EN
      parity_reg     <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      sr_reg         <= sr_next;
      hold_reg       <= hold_next;
      hold_full_reg  <= hold_full_next;
      bit_cnt_reg    <= bit_cnt_next;
      sout_reg       <= sout_next;
      sout_valid_reg <= sout_valid_next;
      word_done_reg  <= word_done_next;
      word_cnt_reg   <= word_cnt_reg + CNT_W'(word_done_reg);
`ifdef SER_PARITY_EN
      parity_reg     <= parity_next;
`endif
    end
  end

endmodule
